// File: rtl/alu_pkg.sv
// Shared constants for the ALU execution stage: datapath width, opcodes and FSM states.
package alu_pkg;

  localparam int unsigned W = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Control/status bundle between the microcode sequencer and the ALU execution stage.
interface alu_exec_if;
  import alu_pkg::*;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   opcode;
  logic         ws;
  logic         busy;
  logic         done;
  logic         zf;
  logic         cf;
  logic         vf;

  modport master (
    output start, op_a, op_b, opcode, ws,
    input  busy, done, zf, cf, vf
  );

  modport slave (
    input  start, op_a, op_b, opcode, ws,
    output busy, done, zf, cf, vf
  );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: result, carry/borrow and overflow for every opcode except MUL.
module alu_comb
  import alu_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [3:0]   i_opcode,
  output logic [W-1:0] o_result,
  output logic         o_cf,
  output logic         o_vf
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = i_a;
    o_cf     = 1'b0;
    o_vf     = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        o_result = w_sum[W-1:0];
        o_cf     = w_sum[W];
        o_vf     = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      OP_SUB, OP_CMP: begin
        o_result = w_diff[W-1:0];
        o_cf     = w_diff[W];
        o_vf     = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      OP_NOT: o_result = ~i_a;
      OP_SHL: begin
        o_result = {i_a[W-2:0], 1'b0};
        o_cf     = i_a[W-1];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[W-1:1]};
        o_cf     = i_a[0];
      end
      OP_INC: begin
        o_result = i_a + W'(1);
        o_cf     = &i_a;
        o_vf     = (i_a == {1'b0, {(W-1){1'b1}}});
      end
      OP_DEC: begin
        o_result = i_a - W'(1);
        o_cf     = ~|i_a;
        o_vf     = (i_a == {1'b1, {(W-1){1'b0}}});
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage: IDLE/EXEC/DONE sequencing, 4-cycle shift-add multiply,
// result/flag registers and the tristate driver onto the shared data bus.
module alu_exec
  import alu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_grst,
  alu_exec_if.slave    bus_if,
  inout  wire [W-1:0]  io_bus
);

  state_e         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [3:0]     r_op;
  logic [1:0]     r_cnt;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_result;
  logic           r_zf;
  logic           r_cf;
  logic           r_vf;
  logic           r_busy;
  logic           r_done;

  logic [W-1:0]   w_alu_res;
  logic           w_alu_cf;
  logic           w_alu_vf;
  logic [2*W-1:0] w_acc_next;

  alu_comb u_alu_comb (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_opcode (r_op),
    .o_result (w_alu_res),
    .o_cf     (w_alu_cf),
    .o_vf     (w_alu_vf)
  );

  // Iteration r_cnt of the multiply adds A<<r_cnt when B[r_cnt] is set.
  assign w_acc_next = r_acc + (r_b[r_cnt] ? ({{W{1'b0}}, r_a} << r_cnt) : '0);

  always_ff @(posedge i_clk) begin
    if (i_grst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
      r_vf     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus_if.start) begin
            r_a     <= bus_if.op_a;
            r_b     <= bus_if.op_b;
            r_op    <= bus_if.opcode;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_op == OP_MUL) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_result <= w_acc_next[W-1:0];
              r_zf     <= (w_acc_next[W-1:0] == '0);
              r_cf     <= |w_acc_next[2*W-1:W];
              r_vf     <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end else begin
            if (r_op == OP_CMP) begin
              r_zf <= (w_alu_res == '0);
              r_cf <= w_alu_cf;
              r_vf <= w_alu_vf;
            end else if (r_op < OP_MUL) begin
              r_result <= w_alu_res;
              r_zf     <= (w_alu_res == '0);
              r_cf     <= w_alu_cf;
              r_vf     <= w_alu_vf;
            end
            // Reserved opcodes fall through: no state change but still pulse done.
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_if.busy = r_busy;
  assign bus_if.done = r_done;
  assign bus_if.zf   = r_zf;
  assign bus_if.cf   = r_cf;
  assign bus_if.vf   = r_vf;

  assign io_bus = bus_if.ws ? r_result : 'z;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_alu_exec;
  import alu_pkg::*;

  logic         clk = 1'b0;
  logic         grst;
  wire  [W-1:0] bus;

  alu_exec_if ifc ();

  alu_exec dut (
    .i_clk  (clk),
    .i_grst (grst),
    .bus_if (ifc),
    .io_bus (bus)
  );

  // Another bus agent drives 5 whenever the ALU should have released the bus.
  assign bus = ifc.ws ? 4'bzzzz : 4'h5;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state.
  bit known = 1'b0;
  bit pend  = 1'b0;
  int busy_from, busy_to, done_cyc, next_free;
  int m_res, m_z, m_c, m_v;
  int p_res, p_z, p_c, p_v;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  function automatic int sval(input int x);
    return (x > 7) ? x - 16 : x;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 7) || (s < -8);
  endfunction

  // Result and flags of one operation, from the opcode table.
  task automatic ref_op(input int a, input int b, input int op,
                        input int pr, input int pz, input int pc, input int pv,
                        output int r, output int z, output int c, output int v);
    int t;
    r = pr; z = pz; c = pc; v = pv;
    case (op)
      0:  begin t = a + b; r = t % 16; c = int'(t > 15); v = int'(ovf(sval(a) + sval(b))); end
      1:  begin r = (a - b + 16) % 16; c = int'(a < b); v = int'(ovf(sval(a) - sval(b))); end
      2:  begin r = a & b; c = 0; v = 0; end
      3:  begin r = a | b; c = 0; v = 0; end
      4:  begin r = a ^ b; c = 0; v = 0; end
      5:  begin r = 15 - a; c = 0; v = 0; end
      6:  begin r = (a * 2) % 16; c = a / 8; v = 0; end
      7:  begin r = a / 2; c = a % 2; v = 0; end
      8:  begin r = (a + 1) % 16; c = int'(a == 15); v = int'(sval(a) + 1 > 7); end
      9:  begin r = (a + 15) % 16; c = int'(a == 0); v = int'(sval(a) - 1 < -8); end
      10: begin t = a * b; r = t % 16; c = int'(t > 15); v = 0; end
      11: begin
        c = int'(a < b);
        v = int'(ovf(sval(a) - sval(b)));
        z = int'(((a - b + 16) % 16) == 0);
      end
      default: ;
    endcase
    if (op <= 10) z = int'(r == 0);
  endtask

  // One clock cycle: compare outputs against the model, then drive new inputs.
  task automatic cyc_do(input bit st, input int a, input int b, input int op,
                        input bit w, input bit rst);
    int k;
    @(negedge clk);
    if (known) begin
      if (pend && cyc == done_cyc) begin
        m_res = p_res; m_z = p_z; m_c = p_c; m_v = p_v;
      end
      chk("busy", int'(ifc.busy), int'(pend && cyc >= busy_from && cyc <= busy_to));
      chk("done", int'(ifc.done), int'(pend && cyc == done_cyc));
      chk("zf", int'(ifc.zf), m_z);
      chk("cf", int'(ifc.cf), m_c);
      chk("vf", int'(ifc.vf), m_v);
      if (ifc.ws) chk("bus_drive", int'(bus), m_res);
      else        chk("bus_release", int'(bus), 5);
      if (pend && cyc >= done_cyc) pend = 1'b0;
    end
    ifc.start  = st;
    ifc.op_a   = a[3:0];
    ifc.op_b   = b[3:0];
    ifc.opcode = op[3:0];
    ifc.ws     = w;
    grst       = rst;
    if (rst) begin
      known = 1'b1;
      pend  = 1'b0;
      m_res = 0; m_z = 0; m_c = 0; m_v = 0;
      next_free = cyc + 1;
    end else if (known && st && cyc >= next_free) begin
      k = (op == 10) ? 4 : 1;
      pend      = 1'b1;
      busy_from = cyc + 1;
      busy_to   = cyc + k;
      done_cyc  = cyc + k + 1;
      next_free = cyc + k + 2;
      ref_op(a, b, op, m_res, m_z, m_c, m_v, p_res, p_z, p_c, p_v);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_do(1'b0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int r, z, c, v;
    grst       = 1'b1;
    ifc.start  = 1'b0;
    ifc.op_a   = '0;
    ifc.op_b   = '0;
    ifc.opcode = '0;
    ifc.ws     = 1'b0;

    // Pin the reference model with hand-computed values.
    ref_op(9, 8, 0, 0, 0, 0, 0, r, z, c, v);
    chk("ref_add_r", r, 1); chk("ref_add_c", c, 1); chk("ref_add_v", v, 1); chk("ref_add_z", z, 0);
    ref_op(3, 5, 1, 0, 0, 0, 0, r, z, c, v);
    chk("ref_sub_r", r, 14); chk("ref_sub_c", c, 1); chk("ref_sub_v", v, 0);
    ref_op(4, 4, 11, 14, 0, 1, 0, r, z, c, v);
    chk("ref_cmp_r", r, 14); chk("ref_cmp_z", z, 1); chk("ref_cmp_c", c, 0);
    ref_op(7, 3, 10, 0, 0, 0, 0, r, z, c, v);
    chk("ref_mul_r", r, 5); chk("ref_mul_c", c, 1);

    // Reset, bus released with ws=0, then driving 0 with ws=1.
    cyc_do(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cyc_do(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cyc_do(1'b0, 0, 0, 0, 1'b0, 1'b0);
    chk("rst_bus_z", int'(bus), 5);
    cyc_do(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(1);
    chk("rst_bus_0", int'(bus), 0);

    // ADD 9+8.
    cyc_do(1'b1, 9, 8, 0, 1'b1, 1'b0);
    idle(1);
    chk("add_busy", int'(ifc.busy), 1);
    idle(1);
    chk("add_done", int'(ifc.done), 1);
    chk("add_res", int'(bus), 1);
    chk("add_cf", int'(ifc.cf), 1);
    chk("add_vf", int'(ifc.vf), 1);

    // SUB 3-5, then CMP 4,4.
    cyc_do(1'b1, 3, 5, 1, 1'b1, 1'b0);
    idle(2);
    chk("sub_res", int'(bus), 14);
    chk("sub_cf", int'(ifc.cf), 1);
    cyc_do(1'b1, 4, 4, 11, 1'b1, 1'b0);
    idle(2);
    chk("cmp_zf", int'(ifc.zf), 1);
    chk("cmp_res", int'(bus), 14);

    // MUL 7x3 with a stray start pulse at t+2.
    cyc_do(1'b1, 7, 3, 10, 1'b1, 1'b0);
    idle(1);
    cyc_do(1'b1, 2, 2, 0, 1'b1, 1'b0);
    idle(3);
    chk("mul_done", int'(ifc.done), 1);
    chk("mul_res", int'(bus), 5);
    chk("mul_cf", int'(ifc.cf), 1);
    idle(3);

    // MUL FxF aborted by reset at t+3, then INC F.
    cyc_do(1'b1, 15, 15, 10, 1'b1, 1'b0);
    idle(2);
    cyc_do(1'b0, 0, 0, 0, 1'b1, 1'b1);
    idle(1);
    chk("abort_res", int'(bus), 0);
    chk("abort_busy", int'(ifc.busy), 0);
    cyc_do(1'b1, 15, 0, 8, 1'b1, 1'b0);
    idle(2);
    chk("inc_res", int'(bus), 0);
    chk("inc_zf", int'(ifc.zf), 1);
    chk("inc_cf", int'(ifc.cf), 1);

    // Result 6, then reserved opcode D.
    cyc_do(1'b1, 2, 4, 0, 1'b1, 1'b0);
    idle(2);
    cyc_do(1'b1, 1, 2, 13, 1'b1, 1'b0);
    idle(2);
    chk("rsv_done", int'(ifc.done), 1);
    chk("rsv_res", int'(bus), 6);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc_do(1'($urandom_range(1)), int'($urandom_range(15)), int'($urandom_range(15)),
             int'($urandom_range(15)), 1'($urandom_range(1)), $urandom_range(63) == 0);
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
